e203_sysmem_icb_sram: RTL and testbench

ICB slave SRAM that terminates the SoC sysmem ICB port, which is currently tied off with a command-to-response loopback. It takes single-beat ICB read and write commands and backs them with an on-chip word array. It has a registered 1-cycle read path and a 2-entry response buffer, so it holds full throughput under rsp_ready backpressure. It sits directly downstream of e203_subsys_top on the sysmem_icb_* bus.

---
 rtl/e203_sysmem_icb_sram.sv | 133 +++++++++++++
 tb/tb_e203_sysmem_icb_sram.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_sysmem_icb_sram.sv
// ICB slave SRAM for the sysmem port: registered 1-cycle read, 2-entry response buffer.
// Optional address range check: define E203_SYSMEM_ADDR_CHK_EN.
module e203_sysmem_icb_sram #(
    parameter int unsigned   AW         = 32,
    parameter int unsigned   DW         = 32,
    parameter int unsigned   DEPTH_LOG2 = 12,
    parameter logic [AW-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sysmem_icb_cmd_valid,
    output logic            sysmem_icb_cmd_ready,
    input  logic            sysmem_icb_cmd_read,
    input  logic [AW-1:0]   sysmem_icb_cmd_addr,
    input  logic [DW-1:0]   sysmem_icb_cmd_wdata,
    input  logic [DW/8-1:0] sysmem_icb_cmd_wmask,
    output logic            sysmem_icb_rsp_valid,
    input  logic            sysmem_icb_rsp_ready,
    output logic            sysmem_icb_rsp_err,
    output logic [DW-1:0]   sysmem_icb_rsp_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned MW    = DW / 8;

    logic [DW-1:0]         mem [DEPTH];
    logic                  cmd_hsk;
    logic                  mem_we;
    logic                  addr_err;
    logic [DEPTH_LOG2-1:0] word_idx;

    logic                  s1_valid_q;
    logic                  s1_err_q;
    logic [DW-1:0]         s1_rdata_q;

    // Each entry holds {err, rdata}
    logic [DW:0]           fifo_data_q [2];
    logic [1:0]            fifo_vld_q;
    logic                  fifo_wr_ptr_q;
    logic                  fifo_rd_ptr_q;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [1:0]            inflight;
    logic                  unused_bits;

    assign word_idx = sysmem_icb_cmd_addr[DEPTH_LOG2+1:2];

`ifdef E203_SYSMEM_ADDR_CHK_EN
    assign addr_err = (sysmem_icb_cmd_addr[AW-1:DEPTH_LOG2+2] != BASE_ADDR[AW-1:DEPTH_LOG2+2]);
`else
    assign addr_err = 1'b0;
`endif

    assign unused_bits = ^{sysmem_icb_cmd_addr[1:0], sysmem_icb_cmd_addr[AW-1:DEPTH_LOG2+2],
                           BASE_ADDR};

    // Credit count is built only from registered state, so rsp_ready never reaches cmd_ready.
    assign fifo_empty = ~|fifo_vld_q;
    assign fifo_full  = &fifo_vld_q;
    assign inflight   = {1'b0, fifo_vld_q[0]} + {1'b0, fifo_vld_q[1]} + {1'b0, s1_valid_q};

    assign sysmem_icb_cmd_ready = (inflight < 2'd2);
    assign cmd_hsk              = sysmem_icb_cmd_valid & sysmem_icb_cmd_ready;
    assign mem_we               = cmd_hsk & ~sysmem_icb_cmd_read & ~addr_err;

    // S1 always leaves each cycle: handshaken directly, or parked in the FIFO.
    assign fifo_pop  = ~fifo_empty & sysmem_icb_rsp_ready;
    assign fifo_push = s1_valid_q & ~(fifo_empty & sysmem_icb_rsp_ready);

    always_comb begin
        sysmem_icb_rsp_valid = s1_valid_q;
        sysmem_icb_rsp_err   = s1_err_q;
        sysmem_icb_rsp_rdata = s1_rdata_q;
        if (!fifo_empty) begin
            sysmem_icb_rsp_valid = 1'b1;
            sysmem_icb_rsp_err   = fifo_data_q[fifo_rd_ptr_q][DW];
            sysmem_icb_rsp_rdata = fifo_data_q[fifo_rd_ptr_q][DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < MW; b++) begin
                if (sysmem_icb_cmd_wmask[b]) begin
                    mem[word_idx][8*b +: 8] <= sysmem_icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_rdata_q <= '0;
        end else begin
            s1_valid_q <= cmd_hsk;
            s1_err_q   <= cmd_hsk & addr_err;
            if (cmd_hsk && sysmem_icb_cmd_read && !addr_err) begin
                s1_rdata_q <= mem[word_idx];
            end else begin
                s1_rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_vld_q     <= 2'b00;
            fifo_wr_ptr_q  <= 1'b0;
            fifo_rd_ptr_q  <= 1'b0;
        end else begin
            if (fifo_push) begin
                fifo_data_q[fifo_wr_ptr_q] <= {s1_err_q, s1_rdata_q};
                fifo_vld_q[fifo_wr_ptr_q]  <= 1'b1;
                fifo_wr_ptr_q              <= ~fifo_wr_ptr_q;
            end
            if (fifo_pop) begin
                fifo_vld_q[fifo_rd_ptr_q] <= 1'b0;
                fifo_rd_ptr_q             <= ~fifo_rd_ptr_q;
            end
        end
    end

`ifndef SYNTHESIS
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
`endif

endmodule

// File: tb/tb_e203_sysmem_icb_sram.sv
// Bench for e203_sysmem_icb_sram: directed steps plus random traffic against a
// transaction-level model (word array + queue of outstanding responses).
module tb_e203_sysmem_icb_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int          compared   = 0;
    int          mismatched = 0;
    bit          last_acc;
    logic [31:0] base_addr  = 32'h8000_0000;
    logic [31:0] mm [int];
    logic [32:0] rsp_q [$];

    always #5 clk = ~clk;

    e203_sysmem_icb_sram dut (
        .clk                  (clk),
        .rst                  (rst),
        .sysmem_icb_cmd_valid (cmd_valid),
        .sysmem_icb_cmd_ready (cmd_ready),
        .sysmem_icb_cmd_read  (cmd_read),
        .sysmem_icb_cmd_addr  (cmd_addr),
        .sysmem_icb_cmd_wdata (cmd_wdata),
        .sysmem_icb_cmd_wmask (cmd_wmask),
        .sysmem_icb_rsp_valid (rsp_valid),
        .sysmem_icb_rsp_ready (rsp_ready),
        .sysmem_icb_rsp_err   (rsp_err),
        .sysmem_icb_rsp_rdata (rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of one accepted command: the array image and the response it owes.
    task automatic model_cmd();
        int          idx;
        bit          err;
        logic [31:0] w;
        idx = int'(cmd_addr[13:2]);
`ifdef E203_SYSMEM_ADDR_CHK_EN
        err = (cmd_addr[31:14] != base_addr[31:14]);
`else
        err = 1'b0;
`endif
        if (cmd_read) begin
            rsp_q.push_back({err, err ? 32'h0 : mm[idx]});
        end else begin
            if (!err) begin
                w = mm.exists(idx) ? mm[idx] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (cmd_wmask[b]) w[8*b +: 8] = cmd_wdata[8*b +: 8];
                mm[idx] = w;
            end
            rsp_q.push_back({err, 32'h0});
        end
    endtask

    // One clock: check outputs before the edge, then advance the model across it.
    task automatic step();
        bit exp_ready;
        bit exp_valid;
        bit acc;
        bit hs;
        @(negedge clk);
        exp_ready = (rsp_q.size() < 2);
        exp_valid = (rsp_q.size() != 0);
        chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, exp_ready});
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_valid});
        if (exp_valid) begin
            chk("rsp_rdata", rsp_rdata, rsp_q[0][31:0]);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, rsp_q[0][32]});
        end
        acc = cmd_valid && exp_ready;
        hs  = exp_valid && rsp_ready;
        @(posedge clk);
        if (hs) void'(rsp_q.pop_front());
        if (acc) model_cmd();
        last_acc = acc;
        #1;
    endtask

    task automatic issue(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm, output int ncyc);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = wm;
        ncyc = 0;
        do begin
            step();
            ncyc++;
        end while (!last_acc && ncyc < 50);
        chk("issue_accepted", {31'h0, last_acc}, 32'h1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 8 && rsp_q.size() != 0; k++) step();
        chk("drain_empty", rsp_q.size(), 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
        chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    endtask

    initial begin
        int          n;
        logic [31:0] a;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_read  = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wmask = '0;
        rsp_ready = 1'b1;
        #2;
        chk_reset_outputs("reset");
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Known contents for the words used below
        for (int i = 0; i < 16; i++) issue(1'b0, base_addr + 32'(4 * i), $urandom, 4'hF, n);
        drain();

        // Write then read on the next cycle
        issue(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, n);
        issue(1'b1, 32'h8000_0010, 32'h0, 4'h0, n);
        chk("raw_valid", {31'h0, rsp_valid}, 32'h1);
        chk("raw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("raw_err", {31'h0, rsp_err}, 32'h0);

        // Partial write, then a no-op mask
        issue(1'b0, 32'h8000_0010, 32'h0000_AA00, 4'b0010, n);
        issue(1'b1, 32'h8000_0010, 32'h0, 4'h0, n);
        chk("partial_rdata", rsp_rdata, 32'hDEAD_AAEF);
        issue(1'b0, 32'h8000_0013, 32'hFFFF_FFFF, 4'b0000, n);
        chk("nomask_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        issue(1'b1, 32'h8000_0010, 32'h0, 4'h0, n);
        chk("nomask_rdata", rsp_rdata, 32'hDEAD_AAEF);
        drain();

        // Backpressure: two accepted, third stalls until rsp_ready rises
        rsp_ready = 1'b0;
        issue(1'b1, 32'h8000_0000, 32'h0, 4'h0, n);
        chk("bp_first_cycles", n, 32'h1);
        issue(1'b1, 32'h8000_0004, 32'h0, 4'h0, n);
        chk("bp_second_cycles", n, 32'h1);
        chk("bp_ready_low", {31'h0, cmd_ready}, 32'h0);
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 32'h8000_0008;
        step();
        step();
        rsp_ready = 1'b1;
        issue(1'b1, 32'h8000_0008, 32'h0, 4'h0, n);
        chk("bp_third_cycles", n, 32'h2);
        drain();

        // Full-rate reads
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, base_addr + 32'(4 * i), 32'h0, 4'h0, n);
            chk("tp_cycles", n, 32'h1);
        end
        drain();

        // Out-of-region write
        issue(1'b0, 32'h9000_0010, 32'h1234_5678, 4'hF, n);
`ifdef E203_SYSMEM_ADDR_CHK_EN
        chk("oor_err", {31'h0, rsp_err}, 32'h1);
        chk("oor_rdata", rsp_rdata, 32'h0);
`else
        chk("oor_err", {31'h0, rsp_err}, 32'h0);
`endif
        issue(1'b1, 32'h8000_0010, 32'h0, 4'h0, n);
`ifdef E203_SYSMEM_ADDR_CHK_EN
        chk("oor_readback", rsp_rdata, 32'hDEAD_AAEF);
`else
        chk("oor_readback", rsp_rdata, 32'h1234_5678);
`endif
        drain();

        // Reset mid-operation with two responses outstanding
        rsp_ready = 1'b0;
        issue(1'b1, 32'h8000_0004, 32'h0, 4'h0, n);
        issue(1'b0, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, n);
        #3 rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        rsp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(1'b1, 32'h8000_0020, 32'h0, 4'h0, n);
        chk("post_reset_valid", {31'h0, rsp_valid}, 32'h1);
        chk("post_reset_rdata", rsp_rdata, 32'hCAFE_F00D);
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            a = {(($urandom % 8) == 0) ? 18'($urandom) : base_addr[31:14], 8'h0,
                 4'($urandom), 2'($urandom)};
            cmd_valid = ($urandom % 4) != 0;
            cmd_read  = ($urandom % 2) != 0;
            cmd_addr  = a;
            cmd_wdata = $urandom;
            cmd_wmask = 4'($urandom);
            rsp_ready = ($urandom % 3) != 0;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
